// File: rtl/score_digit_driver.sv
// ============================================================================
// Module : score_digit_driver
// Brief  : Binary score -> BCD (sequential double-dabble) with frame-safe
//          commit, plus raster-to-glyph-cell mapping for a 5x5 glyph ROM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module score_digit_driver #(
    parameter int NUM_DIGITS = 5,
    parameter int SCORE_W    = 16,
    parameter int X0         = 64,
    parameter int Y0         = 16,
    parameter int SCALE_LOG2 = 2
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_load,
    output logic               busy,
    input  logic [10:0]        hcount,
    input  logic [10:0]        vcount,
    output logic [4:0]         letra,
    output logic [3:0]         xcoord,
    output logic [3:0]         ycoord,
    output logic               in_text
);

    localparam int CELL   = 1 << SCALE_LOG2;
    localparam int BOX_W  = NUM_DIGITS * 8 * CELL;
    localparam int BOX_H  = 5 * CELL;
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(SCORE_W + 1);
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [11:0] C_X0    = 12'(X0);
    localparam logic [11:0] C_Y0    = 12'(Y0);
    localparam logic [11:0] C_BOX_W = 12'(BOX_W);
    localparam logic [11:0] C_BOX_H = 12'(BOX_H);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SCORE_W - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]         state_q,  state_d;
    logic [SCORE_W-1:0] bin_q,    bin_d;
    logic [BCD_W-1:0]   bcd_q,    bcd_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [BCD_W-1:0]   pend_q,   pend_d;
    logic [BCD_W-1:0]   disp_q,   disp_d;
    logic               busy_q,   busy_d;
    logic [4:0]         letra_q,  letra_d;
    logic [3:0]         xcoord_q, xcoord_d;
    logic [3:0]         ycoord_q, ycoord_d;
    logic               hit_q,    hit_d;
    logic               in_text_q;

    // ------------------------------------------------------------------
    // Raster geometry
    // ------------------------------------------------------------------
    logic [11:0]       w_rx;
    logic [11:0]       w_ry;
    logic              w_in_x;
    logic              w_in_y;
    logic [SLOT_W-1:0] w_slot;
    logic [2:0]        w_col;
    logic [2:0]        w_row;

    // Negative offsets wrap to values with bit 11 set, which the range test rejects.
    assign w_rx   = {1'b0, hcount} - C_X0;
    assign w_ry   = {1'b0, vcount} - C_Y0;
    assign w_in_x = !w_rx[11] && (w_rx < C_BOX_W);
    assign w_in_y = !w_ry[11] && (w_ry < C_BOX_H);
    assign w_slot = SLOT_W'(w_rx >> (SCALE_LOG2 + 3));
    assign w_col  = 3'(w_rx >> SCALE_LOG2);
    assign w_row  = 3'(w_ry >> SCALE_LOG2);

    // Digit per slot (slot 0 = most significant) and leading-zero blanking.
    logic [3:0]            w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_lead;

    always_comb begin
        w_lead = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_digit[k] = disp_q[(NUM_DIGITS-1-k)*4 +: 4];
            w_lead     = w_lead && (w_digit[k] == 4'd0);
            w_blank[k] = w_lead && (k != NUM_DIGITS - 1);
        end
    end

    logic w_show;
    assign w_show = w_in_x && w_in_y && (w_col < 3'd5) && !w_blank[w_slot];

    always_comb begin
        letra_d  = '0;
        xcoord_d = '0;
        ycoord_d = '0;
        hit_d    = 1'b0;
        if (w_show) begin
            letra_d  = {1'b0, w_digit[w_slot]};
            xcoord_d = {1'b0, w_col};
            ycoord_d = {1'b0, w_row};
            hit_d    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Double-dabble conversion
    // ------------------------------------------------------------------
    logic [BCD_W-1:0] w_adj;
    logic [BCD_W-1:0] w_shifted;

    always_comb begin
        w_adj = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_adj[k*4 +: 4] = (bcd_q[k*4 +: 4] >= 4'd5) ? (bcd_q[k*4 +: 4] + 4'd3)
                                                         : bcd_q[k*4 +: 4];
        end
    end

    assign w_shifted = {w_adj[BCD_W-2:0], bin_q[SCORE_W-1]};

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (score_load) begin
                    bin_d   = score;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d = w_shifted;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    pend_d  = w_shifted;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                // Only swap the shown value while the beam is outside the text rows.
                if (!w_in_y) begin
                    disp_d  = pend_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            disp_q    <= '0;
            busy_q    <= 1'b0;
            letra_q   <= '0;
            xcoord_q  <= '0;
            ycoord_q  <= '0;
            hit_q     <= 1'b0;
            in_text_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            busy_q    <= busy_d;
            letra_q   <= letra_d;
            xcoord_q  <= xcoord_d;
            ycoord_q  <= ycoord_d;
            hit_q     <= hit_d;
            in_text_q <= hit_q;
        end
    end

    assign busy    = busy_q;
    assign letra   = letra_q;
    assign xcoord  = xcoord_q;
    assign ycoord  = ycoord_q;
    assign in_text = in_text_q;

endmodule

`default_nettype wire

// File: tb/tb_score_digit_driver.sv
// ============================================================================
// Module : tb_score_digit_driver
// Brief  : Self-checking bench for score_digit_driver against a decimal model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_digit_driver;

    localparam int ND   = 5;
    localparam int SW   = 16;
    localparam int X0   = 64;
    localparam int Y0   = 16;
    localparam int S    = 2;
    localparam int CELL = 1 << S;

    logic          clk = 1'b0;
    logic          Reset;
    logic [SW-1:0] score;
    logic          score_load;
    logic          busy;
    logic [10:0]   hcount;
    logic [10:0]   vcount;
    logic [4:0]    letra;
    logic [3:0]    xcoord;
    logic [3:0]    ycoord;
    logic          in_text;

    always #5 clk = ~clk;

    score_digit_driver #(
        .NUM_DIGITS (ND),
        .SCORE_W    (SW),
        .X0         (X0),
        .Y0         (Y0),
        .SCALE_LOG2 (S)
    ) u_dut (
        .clk        (clk),
        .Reset      (Reset),
        .score      (score),
        .score_load (score_load),
        .busy       (busy),
        .hcount     (hcount),
        .vcount     (vcount),
        .letra      (letra),
        .xcoord     (xcoord),
        .ycoord     (ycoord),
        .in_text    (in_text)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: displayed value as a plain integer.
    int m_disp   = 0;
    int m_target = 0;
    int m_cnt    = 0;
    bit m_busy   = 1'b0;
    int m_letra  = 0;
    int m_x      = 0;
    int m_y      = 0;
    bit m_hit    = 1'b0;
    bit m_intext = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic model_edge();
        int rx, ry, slot, c, row, p, dg;
        bit hit;
        rx  = int'(hcount) - X0;
        ry  = int'(vcount) - Y0;
        hit = 1'b0;
        dg  = 0;
        c   = 0;
        row = 0;
        if (rx >= 0 && rx < ND * 8 * CELL && ry >= 0 && ry < 5 * CELL) begin
            slot = rx / (8 * CELL);
            c    = (rx / CELL) % 8;
            row  = ry / CELL;
            p    = pow10(ND - 1 - slot);
            if (c < 5 && (slot == ND - 1 || m_disp >= p)) begin
                hit = 1'b1;
                dg  = (m_disp / p) % 10;
            end
        end
        if (Reset) begin
            m_disp = 0; m_target = 0; m_cnt = 0; m_busy = 1'b0;
            m_letra = 0; m_x = 0; m_y = 0; m_hit = 1'b0; m_intext = 1'b0;
        end else begin
            m_intext = m_hit;
            m_hit    = hit;
            m_letra  = hit ? dg  : 0;
            m_x      = hit ? c   : 0;
            m_y      = hit ? row : 0;
            if (m_busy) begin
                if (m_cnt < SW) m_cnt++;
                else if (int'(vcount) < Y0 || int'(vcount) >= Y0 + 5 * CELL) begin
                    m_disp = m_target;
                    m_busy = 1'b0;
                end
            end else if (score_load) begin
                m_busy   = 1'b1;
                m_cnt    = 0;
                m_target = int'(score);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy",    int'(busy),    int'(m_busy));
        chk("letra",   int'(letra),   m_letra);
        chk("xcoord",  int'(xcoord),  m_x);
        chk("ycoord",  int'(ycoord),  m_y);
        chk("in_text", int'(in_text), int'(m_intext));
    endtask

    task automatic load(input int val);
        score      = SW'(val);
        score_load = 1'b1;
        step();
        score_load = 1'b0;
    endtask

    task automatic sweep(input int v, input int h0, input int h1);
        vcount = 11'(v);
        for (int h = h0; h <= h1; h++) begin
            hcount = 11'(h);
            step();
        end
    endtask

    initial begin
        Reset = 1'b1; score = '0; score_load = 1'b0; hcount = '0; vcount = '0;
        repeat (3) step();
        Reset = 1'b0;

        // Empty readout: only the units "0" shows.
        sweep(20, 60, 230);
        hcount = 11'd192;
        step();
        chk("t1_letra",  int'(letra),  0);
        chk("t1_xcoord", int'(xcoord), 0);
        chk("t1_ycoord", int'(ycoord), 1);
        step();
        chk("t1_in_text", int'(in_text), 1);

        // Minimum-latency conversion of 12345.
        vcount = 11'd0;
        load(12345);
        chk("t2_busy_start", int'(busy), 1);
        repeat (16) step();
        chk("t2_busy_last", int'(busy), 1);
        step();
        chk("t2_busy_done", int'(busy), 0);
        hcount = 11'd104; vcount = 11'd28;
        step();
        chk("t2_letra",  int'(letra),  2);
        chk("t2_xcoord", int'(xcoord), 2);
        chk("t2_ycoord", int'(ycoord), 3);
        step();
        chk("t2_in_text", int'(in_text), 1);
        sweep(24, 60, 232);

        // Leading-zero blanking for 7 and 0.
        vcount = 11'd0; load(7); repeat (18) step();
        sweep(20, 60, 232);
        vcount = 11'd0; load(0); repeat (18) step();
        sweep(30, 60, 232);

        // Commit held off while the beam is inside the text rows.
        vcount = 11'd0; load(54321); repeat (18) step();
        vcount = 11'd20; hcount = 11'd150;
        load(4321);
        repeat (25) step();
        chk("t4_busy_held", int'(busy), 1);
        sweep(20, 60, 232);
        vcount = 11'd36;
        step();
        chk("t4_busy_clear", int'(busy), 0);
        sweep(18, 60, 232);

        // Load while busy is dropped; reset aborts a conversion.
        vcount = 11'd0;
        load(500);
        repeat (4) step();
        load(99);
        repeat (20) step();
        sweep(22, 60, 232);
        vcount = 11'd0;
        load(777);
        repeat (7) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("t5_busy_reset", int'(busy), 0);
        sweep(22, 60, 232);

        // Gap column and past-the-box column.
        vcount = 11'd0; load(88888); repeat (18) step();
        vcount = 11'd20; hcount = 11'd84;
        step();
        chk("t6_gap_letra", int'(letra), 0);
        chk("t6_gap_x",     int'(xcoord), 0);
        hcount = 11'd224;
        step();
        chk("t6_edge_y", int'(ycoord), 0);
        step();
        chk("t6_edge_in_text", int'(in_text), 0);

        // Random raster positions with random loads and rare resets.
        for (int i = 0; i < 6000; i++) begin
            hcount = 11'($urandom_range(40, 260));
            if ($urandom_range(0, 3) == 0) vcount = 11'($urandom_range(0, 45));
            score = SW'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            score_load = ($urandom_range(0, 24) == 0);
            Reset = ($urandom_range(0, 499) == 0);
            step();
        end
        score_load = 1'b0; Reset = 1'b0;

        // Raster scan with loads landing at arbitrary beam positions.
        for (int v = 8; v < 44; v++) begin
            vcount = 11'(v);
            for (int h = 56; h < 236; h++) begin
                hcount = 11'(h);
                score = SW'($urandom_range(0, 65535) >> $urandom_range(0, 16));
                score_load = ($urandom_range(0, 60) == 0);
                step();
            end
        end
        score_load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
